mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/sram_lane_dec.sv | 17 +
 rtl/mem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encoding and defaults for the SRAM arbiter
package mem_arbiter_pkg;

  // Owner of the SRAM port: CPU by default, video during a burst, and a
  // forced CPU window after each burst.
  typedef enum logic [1:0] {
    ST_CPU = 2'd0,
    ST_VID = 2'd1,
    ST_GAP = 2'd2
  } arb_state_t;

  localparam int BURST_DEFAULT = 8;
  localparam int GAP_DEFAULT   = 1;

endpackage

// File: rtl/sram_lane_dec.sv
// rtl/sram_lane_dec.sv - byte-lane enable decode for CPU SRAM accesses
module sram_lane_dec (
  input  logic       ben,
  input  logic [1:0] lane,
  output logic [3:0] be_n
);

  // Byte access drives a single lane low; word access drives all lanes low.
  always_comb begin
    be_n = 4'b0000;
    if (ben) begin
      be_n       = 4'b1111;
      be_n[lane] = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/video SRAM arbiter with fixed-length video bursts
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BURST = BURST_DEFAULT,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] adr,
  input  logic        rd,
  input  logic        wr,
  input  logic        ben,
  input  logic [31:0] outbus,
  output logic [31:0] inbus,
  output logic        stallX,
  input  logic        vid_req,
  input  logic [17:0] vid_adr,
  output logic [31:0] vid_data,
  output logic        vid_valid,
  output logic        vid_ovf,
  output logic [17:0] sram_adr,
  output logic [31:0] sram_dout,
  input  logic [31:0] sram_din,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [3:0]  sram_be_n
);

  localparam logic [5:0] CNT_LAST  = 6'(BURST - 1);
  localparam logic [3:0] GCNT_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  arb_state_t  state;
  arb_state_t  state_nx;
  logic        pend;
  logic [17:0] ptr;
  logic [5:0]  cnt;
  logic [3:0]  gcnt;
  logic        in_vid;
  logic        accept;
  logic [3:0]  lane_be_n;
  logic        unused_inputs;

  // Load strobe and the top address bits do not influence the SRAM port.
  assign unused_inputs = &{1'b0, rd, adr[23:20]};

  assign in_vid = (state == ST_VID);
  assign accept = vid_req && !pend && !in_vid;
  assign inbus  = sram_din;

  sram_lane_dec u_lane_dec (
    .ben  (ben),
    .lane (adr[1:0]),
    .be_n (lane_be_n)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_CPU;
    else      state <= state_nx;
  end

  // Next-state logic and SRAM port mux; the CPU write is held off during reset.
  always_comb begin
    state_nx  = state;
    stallX    = in_vid;
    sram_dout = outbus;
    sram_adr  = adr[19:2];
    sram_oe_n = wr;
    sram_we_n = ~(wr & rst);
    sram_be_n = lane_be_n;
    case (state)
      ST_CPU: if (pend) state_nx = ST_VID;
      ST_VID: if (cnt == CNT_LAST) state_nx = (GAP == 0) ? ST_CPU : ST_GAP;
      ST_GAP: if (gcnt == GCNT_LAST) state_nx = ST_CPU;
      default: state_nx = ST_CPU;
    endcase
    if (in_vid) begin
      sram_adr  = ptr;
      sram_oe_n = 1'b0;
      sram_we_n = 1'b1;
      sram_be_n = 4'b0000;
    end
  end

  // Request latch, burst pointer and the burst / gap counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
      ptr  <= '0;
      cnt  <= '0;
      gcnt <= '0;
    end else begin
      if (accept) begin
        pend <= 1'b1;
        ptr  <= vid_adr;
      end else if (state == ST_CPU && pend) begin
        pend <= 1'b0;
        cnt  <= '0;
      end
      if (in_vid) begin
        ptr <= ptr + 18'd1;
        cnt <= cnt + 6'd1;
      end
      if (state_nx == ST_GAP && state != ST_GAP) gcnt <= '0;
      else if (state == ST_GAP)                  gcnt <= gcnt + 4'd1;
    end
  end

  // Video word register, valid strobe and overrun pulse, all one cycle late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vid_data  <= '0;
      vid_valid <= 1'b0;
      vid_ovf   <= 1'b0;
    end else begin
      vid_valid <= in_vid;
      vid_ovf   <= vid_req && (pend || in_vid);
      if (in_vid) vid_data <= sram_din;
    end
  end

endmodule
